oled_text_ctrl: RTL
===================

Name: oled_text_ctrl

Overview:
Parametrised successor to the fixed 4x16 OLED text engine. It holds a PAGES x COLS character grid and renders each cell through an external glyph ROM. Rendered bytes go out through an external SPI byte sender. Unlike the fixed engine, it supports an incremental mode that redraws only changed cells (tracked against an internal shadow buffer), a one-shot forced full redraw, configurable ROM read latency, and a programmable refresh interval.

Parameters:
PAGES, 4, text rows (OLED pages); power of two, max 8
COLS, 16, characters per row; power of two, max 16
GLYPH_W, 8, bytes (columns) per glyph; fixed 8
ROM_LAT, 2, cycles from rom_addr to valid rom_dout; 1..4
REFRESH_MS, 100, value driven on delay_ms between frames; 12 bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; low returns the block to IDLE at the next frame boundary
incr  in  1  1 = incremental (dirty cells only), 0 = full redraw every frame; sampled in SNAP
force  in  1  pulse; the next frame is a full redraw regardless of incr
char_data  in  PAGES*COLS*8  grid; cell 0 is in the MSBs, row-major
rom_addr  out  11  {char, glyph column[2:0]}
rom_dout  in  8  glyph byte
spi_en  out  1  byte request to SPI sender
spi_data  out  8  byte to send
spi_fin  in  1  byte done from SPI sender
dc  out  1  0 = command, 1 = data
delay_en  out  1  delay request
delay_ms  out  12  delay length
delay_fin  in  1  delay done
busy  out  1  high in every state except IDLE and FDELAY
fin  out  1  one-cycle pulse on frame completion
cells_sent  out  8  number of cells drawn in the last frame; updated at DONE

Behaviour:
- Reset values: all outputs 0, state IDLE, shadow valid bits cleared, force_pend=0.
- force is latched into force_pend on any cycle. force_pend is cleared in SNAP.
- IDLE: when en=1, go to SNAP.
- SNAP (1 cycle):
  - Register char_data into snap[].
  - Set full = !incr | force_pend | any shadow invalid.
  - Set cell index = 0, last_sent = none.
- SCAN:
  - Cell is dirty if full, or snap != shadow, or shadow invalid.
  - Clean cell: advance the index one cell per cycle.
  - Dirty cell whose predecessor in the same page was last_sent: go to GLYPH (column auto-increments).
  - Any other dirty cell: go to ADDR.
  - After the last cell, go to DONE.
- ADDR: with dc=0, send 0x22, {5'b0,page}, 0x00|col_lo, 0x10|col_hi, where col = index_in_page*GLYPH_W. Then set dc=1 and go to GLYPH.
- GLYPH, for k = 0..7:
  - Drive rom_addr = {snap[cell], k}.
  - Wait exactly ROM_LAT cycles, then capture rom_dout into spi_data and send it.
  - After byte 7: write shadow[cell]=snap[cell], set valid, set last_sent=cell, increment the sent counter, return to SCAN at the next cell.
- Byte send handshake:
  - Set spi_en=1, holding spi_data stable, until the cycle spi_fin=1 is seen.
  - Then drive spi_en=0 for at least one cycle before the next request.
  - Sending one byte takes at least 3 cycles of overhead plus the sender's time.
- DONE: pulse fin for one cycle and latch cells_sent.
  - en=0: go to IDLE.
  - en=1: go to FDELAY.
- FDELAY:
  - Drive delay_ms=REFRESH_MS and delay_en=1 until delay_fin.
  - Then drive delay_en=0 for one cycle and go to SNAP.
  - If en drops during FDELAY, finish the delay, then go to IDLE.
- Boundaries:
  - char_data changes mid-frame are ignored until the next SNAP.
  - force arriving during a frame applies to the next frame.
  - Incremental frame with no dirty cells: no SPI traffic; fin still pulses and cells_sent=0.
  - en=0 mid-frame does not abort; the frame completes.
  - rst low mid-transfer: spi_en and delay_en drop immediately and the shadow is invalidated, so the first frame after reset is full.
- Widths:
  - cell index is log2(PAGES*COLS) bits; page = index / COLS, column = index % COLS.
  - col fits in 8 bits for COLS*GLYPH_W <= 128.

Decomposition:
- Shared package oled_pkg:
  - state encodings (replacing the per-state defines)
  - SSD1306 command bytes: CMD_PAGE=0x22, COL_LO=0x00, COL_HI=0x10
  - ROM address width
- One sub-module, oled_cell_scan: holds snap/shadow/valid, does the dirty compare, and produces the next dirty index plus a contiguous flag.
- spi_ctrl, delay_gen and char_rom remain external instances.

Test Plan:
- Reset, then en=1, incr=1, grid all 0x41 -> first frame full:
  - 64 cells, 4 address sequences, 512 data bytes with dc=1
  - fin pulse, cells_sent=64
- Second frame with no change -> zero spi_en assertions; fin pulses after the delay; cells_sent=0.
- Change cells 5 and 6 (page 0) -> one address sequence 0x22,0x00,0x08,0x12 (col 40), then 16 data bytes; cells_sent=2.
- Change cells 15 and 16 -> two address sequences (page 0 col 120, i.e. 0x22,0x00,0x08,0x17; page 1 col 0) and 16 data bytes.
- force pulse while incr=1 -> next frame sends all 64 cells; the following frame sends 0.
- ROM_LAT=3 with the bench ROM delaying 3 cycles -> captured bytes match the ROM pattern. Then assert rst low while spi_en=1 -> spi_en=0 immediately, and the next frame is full.

Source files
------------

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Shared definitions for the OLED text engine: FSM state
//                encodings, SSD1306 addressing command bytes and the glyph
//                ROM address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

    // Glyph ROM address = {character code[7:0], glyph column[2:0]}
    localparam int ROM_AW = 11;

    // SSD1306 addressing command bytes
    localparam logic [7:0] CMD_PAGE = 8'h22;
    localparam logic [7:0] COL_LO   = 8'h00;
    localparam logic [7:0] COL_HI   = 8'h10;

    // Controller states. ADDR/AGAP and GTX/GGAP are the request and
    // mandatory low-gap halves of one SPI byte; FWAIT/FGAP likewise for
    // the inter-frame delay.
    typedef logic [3:0] state_t;
    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_SNAP  = 4'd1;
    localparam state_t S_SCAN  = 4'd2;
    localparam state_t S_ADDR  = 4'd3;
    localparam state_t S_AGAP  = 4'd4;
    localparam state_t S_GRD   = 4'd5;
    localparam state_t S_GTX   = 4'd6;
    localparam state_t S_GGAP  = 4'd7;
    localparam state_t S_DONE  = 4'd8;
    localparam state_t S_FWAIT = 4'd9;
    localparam state_t S_FGAP  = 4'd10;

    // Selects one of the four bytes of the page/column address sequence.
    function automatic logic [7:0] addr_byte(input logic [1:0] sel,
                                             input logic [2:0] page,
                                             input logic [7:0] col);
        case (sel)
            2'd0:    addr_byte = CMD_PAGE;
            2'd1:    addr_byte = {5'b0, page};
            2'd2:    addr_byte = COL_LO | {4'b0, col[3:0]};
            default: addr_byte = COL_HI | {4'b0, col[7:4]};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/oled_cell_scan.sv
`default_nettype none
// ============================================================================
//  Module      : oled_cell_scan
//  Description : Holds the per-frame snapshot of the character grid, the
//                shadow copy of what is currently on the panel and the shadow
//                valid bits. For the cell at idx_i it reports the character,
//                whether the cell must be drawn, and whether it directly
//                follows the last cell drawn on the same page (so the panel's
//                column auto-increment can be reused).
//  Ports       : clk_i/rst_ni   clock, async active-low reset
//                load_i         capture char_data_i into the snapshot
//                char_data_i    grid, cell 0 in the MSBs
//                full_i         treat every cell as dirty
//                idx_i          cell under inspection
//                commit_i       cell idx_i has been drawn
//                char_o         snapshot character at idx_i
//                dirty_o        cell idx_i must be drawn
//                contig_o       cell idx_i - 1 was the last cell drawn
//                any_inval_o    at least one shadow entry is invalid
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_cell_scan #(
    parameter int PAGES = 4,
    parameter int COLS  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        load_i,
    input  logic [PAGES*COLS*8-1:0]     char_data_i,
    input  logic                        full_i,
    input  logic [((PAGES*COLS > 1) ? $clog2(PAGES*COLS) : 1)-1:0] idx_i,
    input  logic                        commit_i,
    output logic [7:0]                  char_o,
    output logic                        dirty_o,
    output logic                        contig_o,
    output logic                        any_inval_o
);

    localparam int N  = PAGES * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(COLS);

    logic [7:0]    snap_q   [N];
    logic [7:0]    shadow_q [N];
    logic [N-1:0]  valid_q;
    logic          last_vld_q;
    logic [IW-1:0] last_q;
    logic          w_col_first;

    // Character storage needs no reset: the valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            for (int i = 0; i < N; i++) begin
                snap_q[i] <= char_data_i[(N-1-i)*8 +: 8];
            end
        end
        if (commit_i) begin
            shadow_q[idx_i] <= snap_q[idx_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            last_vld_q <= 1'b0;
            last_q     <= '0;
        end else begin
            if (commit_i) begin
                valid_q[idx_i] <= 1'b1;
            end
            if (load_i) begin
                last_vld_q <= 1'b0;
            end else if (commit_i) begin
                last_vld_q <= 1'b1;
                last_q     <= idx_i;
            end
        end
    end

    // The first cell of each page never continues the previous page.
    generate
        if (CW > 0) begin : g_col_multi
            assign w_col_first = (idx_i[CW-1:0] == '0);
        end else begin : g_col_single
            assign w_col_first = 1'b1;
        end
    endgenerate

    assign char_o      = snap_q[idx_i];
    assign dirty_o     = full_i | ~valid_q[idx_i] | (snap_q[idx_i] != shadow_q[idx_i]);
    assign contig_o    = last_vld_q & ~w_col_first & (last_q == (idx_i - IW'(1)));
    assign any_inval_o = ~&valid_q;

endmodule
`default_nettype wire

// File: rtl/oled_text_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oled_text_ctrl
//  Description : PAGES x COLS OLED text engine. Each frame snapshots the
//                grid, then draws either every cell or only cells that differ
//                from the shadow copy, fetching glyph bytes from an external
//                ROM and sending them through an external SPI byte sender.
//                Frames are separated by a programmable delay.
//  Ports       : clk_i/rst_ni            clock, async active-low reset
//                en_i, incr_i, force_i   run enable, incremental mode, force
//                char_data_i             grid, cell 0 in the MSBs
//                rom_addr_o/rom_dout_i   glyph ROM
//                spi_en_o/spi_data_o/spi_fin_i/dc_o   SPI byte sender
//                delay_en_o/delay_ms_o/delay_fin_i    delay generator
//                busy_o, fin_o, cells_sent_o          status
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_text_ctrl
    import oled_pkg::*;
#(
    parameter int          PAGES      = 4,
    parameter int          COLS       = 16,
    parameter int          GLYPH_W    = 8,
    parameter int          ROM_LAT    = 2,
    parameter logic [11:0] REFRESH_MS = 12'd100
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    incr_i,
    input  logic                    force_i,
    input  logic [PAGES*COLS*8-1:0] char_data_i,
    output logic [ROM_AW-1:0]       rom_addr_o,
    input  logic [7:0]              rom_dout_i,
    output logic                    spi_en_o,
    output logic [7:0]              spi_data_o,
    input  logic                    spi_fin_i,
    output logic                    dc_o,
    output logic                    delay_en_o,
    output logic [11:0]             delay_ms_o,
    input  logic                    delay_fin_i,
    output logic                    busy_o,
    output logic                    fin_o,
    output logic [7:0]              cells_sent_o
);

    localparam int N  = PAGES * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(COLS);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [2:0]    cnt_q, cnt_d;       // address byte / glyph column
    logic [2:0]    wait_q, wait_d;     // ROM latency counter
    logic [7:0]    glyph_q, glyph_d;
    logic          full_q, full_d;
    logic          force_pend_q, force_pend_d;
    logic          dc_q, dc_d;
    logic [7:0]    sent_q, sent_d;
    logic [7:0]    cells_sent_q, cells_sent_d;

    logic          w_commit;
    logic          w_last;
    logic [7:0]    w_char;
    logic          w_dirty;
    logic          w_contig;
    logic          w_any_inval;
    logic [7:0]    w_idx8;
    logic [2:0]    w_page;
    logic [7:0]    w_col;

    oled_cell_scan #(
        .PAGES (PAGES),
        .COLS  (COLS)
    ) u_scan (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (state_q == S_SNAP),
        .char_data_i (char_data_i),
        .full_i      (full_q),
        .idx_i       (idx_q),
        .commit_i    (w_commit),
        .char_o      (w_char),
        .dirty_o     (w_dirty),
        .contig_o    (w_contig),
        .any_inval_o (w_any_inval)
    );

    assign w_last = (idx_q == IW'(N - 1));
    assign w_idx8 = 8'(idx_q);
    assign w_page = 3'(w_idx8 >> CW);
    assign w_col  = (w_idx8 & 8'(COLS - 1)) * 8'(GLYPH_W);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en_i) state_d = S_SNAP;
            S_SNAP:  state_d = S_SCAN;
            S_SCAN: begin
                if (w_dirty) begin
                    state_d = w_contig ? S_GRD : S_ADDR;
                end else if (w_last) begin
                    state_d = S_DONE;
                end
            end
            S_ADDR:  if (spi_fin_i) state_d = S_AGAP;
            S_AGAP:  state_d = (cnt_q == 3'd3) ? S_GRD : S_ADDR;
            S_GRD:   if (wait_q == 3'(ROM_LAT)) state_d = S_GTX;
            S_GTX:   if (spi_fin_i) state_d = S_GGAP;
            S_GGAP: begin
                if (cnt_q != 3'd7) begin
                    state_d = S_GRD;
                end else begin
                    state_d = w_last ? S_DONE : S_SCAN;
                end
            end
            S_DONE:  state_d = en_i ? S_FWAIT : S_IDLE;
            S_FWAIT: if (delay_fin_i) state_d = S_FGAP;
            S_FGAP:  state_d = en_i ? S_SNAP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        glyph_d      = glyph_q;
        full_d       = full_q;
        dc_d         = dc_q;
        sent_d       = sent_q;
        cells_sent_d = cells_sent_q;
        w_commit     = 1'b0;
        // A force seen in the SNAP cycle stays pending for the next frame.
        force_pend_d = force_i | (force_pend_q & (state_q != S_SNAP));

        case (state_q)
            S_SNAP: begin
                idx_d  = '0;
                sent_d = '0;
                full_d = ~incr_i | force_pend_q | w_any_inval;
            end
            S_SCAN: begin
                if (w_dirty) begin
                    cnt_d  = '0;
                    wait_d = '0;
                    if (!w_contig) dc_d = 1'b0;
                end else if (!w_last) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_AGAP: begin
                if (cnt_q == 3'd3) begin
                    cnt_d  = '0;
                    wait_d = '0;
                    dc_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_GRD: begin
                if (wait_q == 3'(ROM_LAT)) begin
                    glyph_d = rom_dout_i;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_GGAP: begin
                if (cnt_q == 3'd7) begin
                    w_commit = 1'b1;
                    sent_d   = sent_q + 8'd1;
                    if (!w_last) idx_d = idx_q + IW'(1);
                end else begin
                    cnt_d  = cnt_q + 3'd1;
                    wait_d = '0;
                end
            end
            default: ;
        endcase

        // Latched on entry so the count is already valid while fin pulses.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            cells_sent_d = sent_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q        <= '0;
            cnt_q        <= '0;
            wait_q       <= '0;
            glyph_q      <= '0;
            full_q       <= 1'b0;
            force_pend_q <= 1'b0;
            dc_q         <= 1'b0;
            sent_q       <= '0;
            cells_sent_q <= '0;
        end else begin
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            glyph_q      <= glyph_d;
            full_q       <= full_d;
            force_pend_q <= force_pend_d;
            dc_q         <= dc_d;
            sent_q       <= sent_d;
            cells_sent_q <= cells_sent_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from state so reset drops requests immediately)
    // ------------------------------------------------------------------
    always_comb begin
        spi_en_o   = 1'b0;
        spi_data_o = 8'h00;
        rom_addr_o = '0;
        delay_en_o = 1'b0;
        delay_ms_o = 12'd0;
        fin_o      = 1'b0;
        busy_o     = 1'b1;
        case (state_q)
            S_IDLE:  busy_o = 1'b0;
            S_ADDR: begin
                spi_en_o   = 1'b1;
                spi_data_o = addr_byte(cnt_q[1:0], w_page, w_col);
            end
            S_GRD:   rom_addr_o = {w_char, cnt_q};
            S_GTX: begin
                spi_en_o   = 1'b1;
                spi_data_o = glyph_q;
            end
            S_DONE:  fin_o = 1'b1;
            S_FWAIT: begin
                busy_o     = 1'b0;
                delay_en_o = 1'b1;
                delay_ms_o = REFRESH_MS;
            end
            S_FGAP:  busy_o = 1'b0;
            default: ;
        endcase
    end

    assign dc_o         = dc_q;
    assign cells_sent_o = cells_sent_q;

endmodule
`default_nettype wire
